video_fb_read_sched: RTL and testbench
======================================

Name: video_fb_read_sched

Overview:
- Sequences framebuffer read traffic for the display path.
- Each frame starts on the rising edge of fbc_vsync from the framebuffer output stage. The block then issues one burst read command per line segment to the memory read port.
- Commands are throttled by a credit check against the pixel line FIFO, so the FIFO never overflows.
- Sits between the video output timing block and the DDR read master, in the pixel_clock domain.

Parameters:
- H_VISIBLE, 1920, visible pixels per line; must be a multiple of BURST_PIX.
- V_VISIBLE, 1080, visible lines per frame.
- BURST_PIX, 64, pixels per read command.
- BYTES_PER_PIX, 4, bytes per pixel in memory.
- LINE_STRIDE, 8192, byte distance between line starts.
- FB_BASE, 32'h0000_0000, byte address of pixel (0,0).
- ADDR_W, 32, command address width.
- FIFO_DEPTH, 512, line FIFO capacity in pixels.
- LVL_W, 10, width of fifo_level; must satisfy 2^LVL_W > FIFO_DEPTH.

Ports:
- pixel_clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new frames to start; sampled only in IDLE/DONE.
- fbc_vsync  in  1  frame marker; its rising edge starts a frame.
- fifo_level  in  LVL_W  current line FIFO occupancy in pixels.
- rd_beat  in  1  one pixel returned from memory and written to the FIFO this cycle.
- cmd_valid  out  1  read command valid.
- cmd_ready  in  1  read master accepts the command.
- cmd_addr  out  ADDR_W  byte address of the burst.
- cmd_len  out  8  BURST_PIX-1; constant.
- fifo_flush  out  1  one-cycle FIFO clear pulse.
- frame_done  out  1  one-cycle pulse after the last command of a frame is accepted.
- busy  out  1  high in any state other than IDLE/DONE.
- abort_cnt  out  8  saturating count of frames cut short by an early vsync.

Behaviour:
- Reset values: cmd_valid=0, cmd_addr=0, fifo_flush=0, frame_done=0, busy=0, abort_cnt=0, state=IDLE, outstanding=0, vsync edge register=0.
- Edge detection: vs_rise = fbc_vsync & ~fbc_vsync_q, where fbc_vsync_q is a one-flop delayed copy.
- IDLE: on vs_rise & enable, go to FLUSH.
- FLUSH:
  - Lasts 1 cycle with fifo_flush=1.
  - Clears outstanding, burst_idx, line_idx, and line_base/cmd_addr to FB_BASE.
  - Then go to CREDIT.
- CREDIT:
  - Go to ISSUE when fifo_level + outstanding + BURST_PIX <= FIFO_DEPTH.
  - Evaluate this sum at LVL_W+2 bits so it cannot overflow.
- ISSUE:
  - cmd_valid=1 with cmd_addr stable until cmd_ready; valid never drops before the handshake.
  - On accept: outstanding += BURST_PIX, then advance addressing.
  - Next burst, same line: cmd_addr += BURST_PIX*BYTES_PER_PIX.
  - End of line: line_base += LINE_STRIDE, cmd_addr = new line_base.
  - After the last burst of line V_VISIBLE-1: pulse frame_done and go to DONE; otherwise go to CREDIT.
- Outstanding counter:
  - Decrements by 1 on each rd_beat.
  - A simultaneous accept and rd_beat nets +BURST_PIX-1.
  - Floors at 0; an rd_beat at 0 is ignored.
- DONE: on vs_rise & enable, go to FLUSH; on vs_rise & ~enable, go to IDLE.
- Early vsync (vs_rise in CREDIT or ISSUE):
  - abort_cnt increments, saturating at 255.
  - From CREDIT: go to FLUSH next cycle.
  - From ISSUE: the pending command completes its handshake first, then go to FLUSH; no frame_done.
  - A second vs_rise during that wait is absorbed; abort_cnt counts once.
- enable low mid-frame: the current frame finishes normally.
- Address arithmetic uses accumulators only (no multipliers), wrapping at ADDR_W bits.
- Reset mid-operation returns everything to reset values on the next edge, even if cmd_valid was high.
- Latency:
  - vs_rise to fifo_flush: 1 cycle.
  - vs_rise to first cmd_valid: 3 cycles when credit is available (edge → FLUSH → CREDIT → ISSUE).
  - Accept to next cmd_valid: 2 cycles minimum.

Decomposition:
- Package video_fb_pkg holds:
  - the state enum (IDLE, FLUSH, CREDIT, ISSUE, DONE);
  - derived constants BURSTS_PER_LINE = H_VISIBLE/BURST_PIX and BURST_BYTES = BURST_PIX*BYTES_PER_PIX;
  - an elaboration check that H_VISIBLE % BURST_PIX == 0.
- One sub-module, video_fb_addr_gen: burst/line counters and the address accumulator, with load/advance inputs and last_burst/last_line flags.

Test Plan:
- Reset behaviour: hold reset 5 cycles with fbc_vsync toggling -> all outputs 0 and no fifo_flush.
- Full frame: H_VISIBLE=8, BURST_PIX=4, V_VISIBLE=3, LINE_STRIDE=64, FB_BASE=0x1000, BYTES_PER_PIX=4, cmd_ready=1, fifo_level=0, FIFO_DEPTH large, rd_beat returns each issued burst's 4 beats before the next credit check -> six commands at 0x1000, 0x1010, 0x1040, 0x1050, 0x1080, 0x1090, cmd_len=3, one frame_done after the 6th accept.
- Backpressure: cmd_ready low for 10 cycles during the 2nd burst -> cmd_valid stays high and cmd_addr stays 0x1010; only one command is counted.
- Credit stall: FIFO_DEPTH=8, fifo_level=4, rd_beat=0 -> first command accepted, then stall in CREDIT; 4 rd_beat pulses plus fifo_level dropped to 0 -> second command issued.
- Early vsync: vs_rise while cmd_valid=1 and cmd_ready=0 -> command held until cmd_ready, then fifo_flush pulse, abort_cnt=1, addressing restarts at FB_BASE, no frame_done.
- Disable and mid-frame reset: enable=0 at DONE plus vs_rise -> IDLE, busy=0, no flush; reset asserted in ISSUE -> cmd_valid=0 on the next edge.

Source files
------------

// File: rtl/video_fb_read_sched_pkg.sv
// Shared state encodings and elaboration-time helpers for the framebuffer
// read scheduler.
package video_fb_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_FLUSH  = 3'd1;
   localparam state_t S_CREDIT = 3'd2;
   localparam state_t S_ISSUE  = 3'd3;
   localparam state_t S_DONE   = 3'd4;

   localparam int unsigned CMD_LEN_W = 8;

   function automatic int unsigned bursts_per_line(input int unsigned h_visible,
                                                   input int unsigned burst_pix);
      return h_visible / burst_pix;
   endfunction

   function automatic int unsigned burst_bytes(input int unsigned burst_pix,
                                               input int unsigned bytes_per_pix);
      return burst_pix * bytes_per_pix;
   endfunction

   function automatic bit line_splits_evenly(input int unsigned h_visible,
                                             input int unsigned burst_pix);
      return (h_visible % burst_pix) == 0;
   endfunction

endpackage

// File: rtl/video_fb_read_sched_if.sv
// Read-command bus between the scheduler (master) and the DDR read master.
interface video_fb_read_sched_if
   import video_fb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [ADDR_W-1:0]    cmd_addr;
   logic [CMD_LEN_W-1:0] cmd_len;

   modport master (output cmd_valid, output cmd_addr, output cmd_len, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_addr, input cmd_len, output cmd_ready);
endinterface

// File: rtl/video_fb_read_sched_addr_gen.sv
// Burst/line position counters and the running burst address, built from
// accumulators only.
module video_fb_addr_gen #(
   parameter int unsigned        ADDR_W          = 32,
   parameter logic [ADDR_W-1:0]  FB_BASE         = '0,
   parameter int unsigned        LINE_STRIDE     = 8192,
   parameter int unsigned        BURST_BYTES     = 256,
   parameter int unsigned        BURSTS_PER_LINE = 30,
   parameter int unsigned        V_VISIBLE       = 1080
) (
   input  logic              pixel_clock,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic              last_burst,
   output logic              last_line
);
   localparam int unsigned BW = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
   localparam int unsigned LW = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;

   localparam logic [BW-1:0]     BURST_LAST = BW'(BURSTS_PER_LINE - 1);
   localparam logic [LW-1:0]     LINE_LAST  = LW'(V_VISIBLE - 1);
   localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(LINE_STRIDE);
   localparam logic [ADDR_W-1:0] BURST_A    = ADDR_W'(BURST_BYTES);

   logic [BW-1:0]     burst_idx;
   logic [LW-1:0]     line_idx;
   logic [ADDR_W-1:0] line_base;

   assign last_burst = (burst_idx == BURST_LAST);
   assign last_line  = (line_idx == LINE_LAST);

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         burst_idx <= '0;
         line_idx  <= '0;
         line_base <= '0;
         addr      <= '0;
      end else if (load) begin
         burst_idx <= '0;
         line_idx  <= '0;
         line_base <= FB_BASE;
         addr      <= FB_BASE;
      end else if (advance) begin
         if (last_burst) begin
            // new line: both accumulators jump to the next line start
            burst_idx <= '0;
            line_idx  <= last_line ? '0 : line_idx + LW'(1);
            line_base <= line_base + STRIDE_A;
            addr      <= line_base + STRIDE_A;
         end else begin
            burst_idx <= burst_idx + BW'(1);
            addr      <= addr + BURST_A;
         end
      end
   end

endmodule

// File: rtl/video_fb_read_sched.sv
// Framebuffer read scheduler: one burst command per line segment, frame
// started by a vsync rising edge and throttled by line-FIFO credit.
module video_fb_read_sched
   import video_fb_pkg::*;
#(
   parameter int unsigned       H_VISIBLE     = 1920,
   parameter int unsigned       V_VISIBLE     = 1080,
   parameter int unsigned       BURST_PIX     = 64,
   parameter int unsigned       BYTES_PER_PIX = 4,
   parameter int unsigned       LINE_STRIDE   = 8192,
   parameter int unsigned       ADDR_W        = 32,
   parameter logic [ADDR_W-1:0] FB_BASE       = '0,
   parameter int unsigned       FIFO_DEPTH    = 512,
   parameter int unsigned       LVL_W         = 10
) (
   input  logic                    pixel_clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    fbc_vsync,
   input  logic [LVL_W-1:0]        fifo_level,
   input  logic                    rd_beat,
   video_fb_read_sched_if.master   cmd,
   output logic                    fifo_flush,
   output logic                    frame_done,
   output logic                    busy,
   output logic [7:0]              abort_cnt
);
   localparam int unsigned BURSTS_PER_LINE = bursts_per_line(H_VISIBLE, BURST_PIX);
   localparam int unsigned BURST_BYTES     = burst_bytes(BURST_PIX, BYTES_PER_PIX);

   if (!line_splits_evenly(H_VISIBLE, BURST_PIX)) begin : g_bad_h_visible
      $error("H_VISIBLE must be a multiple of BURST_PIX");
   end

   localparam int unsigned        SW        = LVL_W + 2;
   localparam logic [LVL_W-1:0]   BURST_LVL = LVL_W'(BURST_PIX);
   localparam logic [LVL_W-1:0]   BURST_M1  = LVL_W'(BURST_PIX - 1);

   state_t           state;
   state_t           state_nxt;
   logic             vs_q;
   logic             vs_rise;
   logic             accept;
   logic             abort_pend;
   logic             abort_hit;
   logic             credit_ok;
   logic [SW-1:0]    credit_sum;
   logic [LVL_W-1:0] outstanding;
   logic             last_burst;
   logic             last_line;

   assign vs_rise    = fbc_vsync & ~vs_q;
   assign accept     = (state == S_ISSUE) & cmd.cmd_ready;
   assign credit_sum = SW'(fifo_level) + SW'(outstanding) + SW'(BURST_PIX);
   assign credit_ok  = (credit_sum <= SW'(FIFO_DEPTH));
   assign abort_hit  = vs_rise & ((state == S_CREDIT) | ((state == S_ISSUE) & ~abort_pend));

   assign cmd.cmd_valid = (state == S_ISSUE);
   assign cmd.cmd_len   = CMD_LEN_W'(BURST_PIX - 1);
   assign fifo_flush    = (state == S_FLUSH);
   assign busy          = (state == S_FLUSH) | (state == S_CREDIT) | (state == S_ISSUE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (vs_rise && enable) state_nxt = S_FLUSH;
         S_FLUSH:  state_nxt = S_CREDIT;
         S_CREDIT: begin
            if (vs_rise)        state_nxt = S_FLUSH;
            else if (credit_ok) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            // an early vsync lets the pending handshake finish before restarting
            if (accept) begin
               if (abort_pend || vs_rise)        state_nxt = S_FLUSH;
               else if (last_burst && last_line) state_nxt = S_DONE;
               else                              state_nxt = S_CREDIT;
            end
         end
         S_DONE:   if (vs_rise) state_nxt = enable ? S_FLUSH : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         state       <= S_IDLE;
         vs_q        <= 1'b0;
         abort_pend  <= 1'b0;
         abort_cnt   <= '0;
         frame_done  <= 1'b0;
         outstanding <= '0;
      end else begin
         state      <= state_nxt;
         vs_q       <= fbc_vsync;
         frame_done <= accept & last_burst & last_line & ~abort_pend & ~vs_rise;

         if (abort_hit && (abort_cnt != '1)) abort_cnt <= abort_cnt + 8'd1;

         if (state == S_FLUSH)
            abort_pend <= 1'b0;
         else if ((state == S_ISSUE) && vs_rise && !accept)
            abort_pend <= 1'b1;

         if (state == S_FLUSH) begin
            outstanding <= '0;
         end else begin
            case ({accept, rd_beat})
               2'b10:   outstanding <= outstanding + BURST_LVL;
               2'b11:   outstanding <= outstanding + BURST_M1;
               2'b01:   if (outstanding != '0) outstanding <= outstanding - LVL_W'(1);
               default: outstanding <= outstanding;
            endcase
         end
      end
   end

   video_fb_addr_gen #(
      .ADDR_W          (ADDR_W),
      .FB_BASE         (FB_BASE),
      .LINE_STRIDE     (LINE_STRIDE),
      .BURST_BYTES     (BURST_BYTES),
      .BURSTS_PER_LINE (BURSTS_PER_LINE),
      .V_VISIBLE       (V_VISIBLE)
   ) u_addr_gen (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .load        (state == S_FLUSH),
      .advance     (accept),
      .addr        (cmd.cmd_addr),
      .last_burst  (last_burst),
      .last_line   (last_line)
   );

endmodule

// File: tb/tb_video_fb_read_sched.sv
// Bench for video_fb_read_sched: directed scenarios plus randomized traffic,
// all checked every cycle against a frame-level reference model.
module tb_video_fb_read_sched;

   localparam int unsigned H_VISIBLE  = 8;
   localparam int unsigned V_VISIBLE  = 3;
   localparam int unsigned BURST_PIX  = 4;
   localparam int unsigned BPP        = 4;
   localparam int unsigned STRIDE     = 64;
   localparam logic [31:0] BASE       = 32'h1000;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned LVL_W      = 4;
   localparam int          BPL        = H_VISIBLE / BURST_PIX;
   localparam int          TOTAL      = BPL * V_VISIBLE;

   localparam int M_IDLE = 0, M_FLUSH = 1, M_CREDIT = 2, M_ISSUE = 3, M_DONE = 4;

   logic             pixel_clock = 1'b0;
   logic             reset       = 1'b1;
   logic             enable      = 1'b0;
   logic             fbc_vsync   = 1'b0;
   logic             rd_beat     = 1'b0;
   logic [LVL_W-1:0] fifo_level  = '0;
   logic             fifo_flush;
   logic             frame_done;
   logic             busy;
   logic [7:0]       abort_cnt;

   video_fb_read_sched_if #(.ADDR_W(32)) bus ();

   video_fb_read_sched #(
      .H_VISIBLE     (H_VISIBLE),
      .V_VISIBLE     (V_VISIBLE),
      .BURST_PIX     (BURST_PIX),
      .BYTES_PER_PIX (BPP),
      .LINE_STRIDE   (STRIDE),
      .ADDR_W        (32),
      .FB_BASE       (BASE),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .LVL_W         (LVL_W)
   ) dut (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .enable      (enable),
      .fbc_vsync   (fbc_vsync),
      .fifo_level  (fifo_level),
      .rd_beat     (rd_beat),
      .cmd         (bus.master),
      .fifo_flush  (fifo_flush),
      .frame_done  (frame_done),
      .busy        (busy),
      .abort_cnt   (abort_cnt)
   );

   always #5 pixel_clock = ~pixel_clock;

   int n_pass  = 0;
   int n_total = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // ---------------- reference model (frame-level) ----------------
   int m_ph = M_IDLE, m_k = 0, m_out = 0, m_ab = 0;
   bit m_pend = 0, m_fd = 0, m_vs = 0, m_started = 0;

   function automatic logic [31:0] model_addr(input int k);
      return BASE + 32'((k / BPL) * STRIDE + (k % BPL) * BURST_PIX * BPP);
   endfunction

   always @(posedge pixel_clock) begin
      int nph;
      bit rise, acc;
      if (reset) begin
         m_ph = M_IDLE; m_k = 0; m_out = 0; m_ab = 0; m_pend = 0; m_fd = 0; m_vs = 0;
      end else begin
         rise = fbc_vsync && !m_vs;
         acc  = (m_ph == M_ISSUE) && bus.cmd_ready;
         nph  = m_ph;
         m_fd = 0;
         case (m_ph)
            M_IDLE:   if (rise && enable) nph = M_FLUSH;
            M_FLUSH:  begin m_k = 0; m_pend = 0; nph = M_CREDIT; end
            M_CREDIT: begin
               if (rise) begin
                  if (m_ab < 255) m_ab++;
                  nph = M_FLUSH;
               end else if (int'(fifo_level) + m_out + BURST_PIX <= FIFO_DEPTH) nph = M_ISSUE;
            end
            M_ISSUE: begin
               if (rise && !m_pend) begin
                  if (m_ab < 255) m_ab++;
                  m_pend = 1;
               end
               if (acc) begin
                  if (m_pend) nph = M_FLUSH;
                  else if (m_k == TOTAL - 1) begin m_fd = 1; nph = M_DONE; end
                  else begin m_k++; nph = M_CREDIT; end
               end
            end
            M_DONE:   if (rise) nph = enable ? M_FLUSH : M_IDLE;
            default:  nph = M_IDLE;
         endcase
         if (m_ph == M_FLUSH) m_out = 0;
         else begin
            if (acc) m_out += BURST_PIX;
            if (rd_beat && m_out > 0) m_out--;
         end
         m_ph = nph;
         m_vs = fbc_vsync;
      end
      m_started = 1;
   end

   // ---------------- per-cycle compare + event capture ----------------
   logic [31:0] acc_q[$];
   int fd_cnt = 0, fl_cnt = 0, owed = 0;
   bit drain = 1, random_beats = 0;

   always @(negedge pixel_clock) begin
      if (m_started) begin
         check("cmd_valid", 32'(bus.cmd_valid), 32'(m_ph == M_ISSUE));
         if (m_ph == M_ISSUE) check("cmd_addr", bus.cmd_addr, model_addr(m_k));
         check("cmd_len", 32'(bus.cmd_len), BURST_PIX - 1);
         check("fifo_flush", 32'(fifo_flush), 32'(m_ph == M_FLUSH));
         check("frame_done", 32'(frame_done), 32'(m_fd));
         check("busy", 32'(busy), 32'(m_ph == M_FLUSH || m_ph == M_CREDIT || m_ph == M_ISSUE));
         check("abort_cnt", 32'(abort_cnt), 32'(m_ab));
      end
      if (reset) owed = 0;
      else if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
         acc_q.push_back(bus.cmd_addr);
         owed += BURST_PIX;
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (fifo_flush === 1'b1) fl_cnt++;
   end

   // memory return beats: sole driver of rd_beat
   always begin
      @(posedge pixel_clock);
      #1;
      if (random_beats) rd_beat = 1'($urandom_range(0, 1));
      else if (drain && owed > 0) begin rd_beat = 1'b1; owed--; end
      else rd_beat = 1'b0;
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge pixel_clock);
      #1;
   endtask

   task automatic vs_pulse();
      fbc_vsync = 1'b1; cyc(1);
      fbc_vsync = 1'b0; cyc(1);
   endtask

   task automatic wait_acc(input int n);
      int t = 0;
      while (acc_q.size() < n && t < 300) begin cyc(1); t++; end
      check("wait_accept", 32'(acc_q.size() >= n), 1);
   endtask

   task automatic wait_fd(input int n);
      int t = 0;
      while (fd_cnt < n && t < 300) begin cyc(1); t++; end
      check("wait_frame_done", 32'(fd_cnt >= n), 1);
   endtask

   task automatic wait_flush(input int n);
      int t = 0;
      while (fl_cnt < n && t < 300) begin cyc(1); t++; end
      check("wait_flush", 32'(fl_cnt >= n), 1);
   endtask

   task automatic wait_valid();
      int t = 0;
      while (bus.cmd_valid !== 1'b1 && t < 300) begin cyc(1); t++; end
      check("wait_valid", 32'(bus.cmd_valid), 1);
   endtask

   logic [31:0] exp_addr [6] = '{32'h1000, 32'h1010, 32'h1040, 32'h1050, 32'h1080, 32'h1090};

   initial begin
      int fd0, fl0;
      bus.cmd_ready = 1'b0;

      // reset held with vsync toggling
      for (int i = 0; i < 5; i++) begin
         fbc_vsync = ~fbc_vsync;
         cyc(1);
      end
      @(negedge pixel_clock);
      check("rst_flush", 32'(fifo_flush), 0);
      check("rst_valid", 32'(bus.cmd_valid), 0);
      check("rst_addr", bus.cmd_addr, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_abort", 32'(abort_cnt), 0);
      check("rst_flush_seen", 32'(fl_cnt), 0);
      fbc_vsync = 1'b0;
      cyc(1);
      reset = 1'b0;
      cyc(2);

      // full frame with latency pins
      acc_q.delete();
      fd0 = fd_cnt;
      enable = 1'b1; bus.cmd_ready = 1'b1; fifo_level = '0; drain = 1;
      fbc_vsync = 1'b1; cyc(1);
      check("lat_flush", 32'(fifo_flush), 1);
      fbc_vsync = 1'b0; cyc(1);
      check("lat_valid_early", 32'(bus.cmd_valid), 0);
      cyc(1);
      check("lat_valid", 32'(bus.cmd_valid), 1);
      wait_fd(fd0 + 1);
      cyc(2);
      check("frame_cmds", 32'(acc_q.size()), 6);
      for (int i = 0; i < 6 && i < acc_q.size(); i++) check("frame_addr", acc_q[i], exp_addr[i]);
      check("frame_done_cnt", 32'(fd_cnt), 32'(fd0 + 1));

      // backpressure on the 2nd burst
      acc_q.delete();
      fd0 = fd_cnt;
      vs_pulse();
      wait_acc(1);
      bus.cmd_ready = 1'b0;
      cyc(1);
      for (int i = 0; i < 10; i++) begin
         @(negedge pixel_clock);
         check("bp_valid", 32'(bus.cmd_valid), 1);
         check("bp_addr", bus.cmd_addr, 32'h1010);
      end
      cyc(1);
      bus.cmd_ready = 1'b1;
      wait_fd(fd0 + 1);
      cyc(1);
      check("bp_cmds", 32'(acc_q.size()), 6);
      if (acc_q.size() >= 3) begin
         check("bp_addr1", acc_q[1], 32'h1010);
         check("bp_addr2", acc_q[2], 32'h1040);
      end

      // credit stall
      acc_q.delete();
      fd0 = fd_cnt;
      drain = 0; fifo_level = 4'd4;
      vs_pulse();
      wait_acc(1);
      cyc(5);
      @(negedge pixel_clock);
      check("stall_busy", 32'(busy), 1);
      check("stall_valid", 32'(bus.cmd_valid), 0);
      check("stall_cmds", 32'(acc_q.size()), 1);
      cyc(1);
      fifo_level = '0; drain = 1;
      wait_acc(2);
      if (acc_q.size() >= 2) check("stall_addr1", acc_q[1], 32'h1010);
      wait_fd(fd0 + 1);
      cyc(2);

      // early vsync while a command is held
      acc_q.delete();
      fd0 = fd_cnt;
      bus.cmd_ready = 1'b0;
      vs_pulse();
      wait_valid();
      fl0 = fl_cnt;
      vs_pulse();
      cyc(2);
      vs_pulse();
      cyc(2);
      @(negedge pixel_clock);
      check("ev_hold_valid", 32'(bus.cmd_valid), 1);
      check("ev_hold_addr", bus.cmd_addr, 32'h1000);
      check("ev_abort", 32'(abort_cnt), 1);
      check("ev_no_flush_yet", 32'(fl_cnt), 32'(fl0));
      cyc(1);
      bus.cmd_ready = 1'b1;
      wait_flush(fl0 + 1);
      check("ev_abort_once", 32'(abort_cnt), 1);
      check("ev_no_done", 32'(fd_cnt), 32'(fd0));
      wait_acc(2);
      if (acc_q.size() >= 2) begin
         check("ev_addr0", acc_q[0], 32'h1000);
         check("ev_restart", acc_q[1], 32'h1000);
      end
      wait_fd(fd0 + 1);
      check("ev_cmds", 32'(acc_q.size()), 7);
      cyc(2);

      // disable at DONE, then reset in ISSUE
      fl0 = fl_cnt;
      enable = 1'b0;
      vs_pulse();
      cyc(2);
      vs_pulse();
      @(negedge pixel_clock);
      check("dis_busy", 32'(busy), 0);
      check("dis_no_flush", 32'(fl_cnt), 32'(fl0));
      cyc(1);
      enable = 1'b1; bus.cmd_ready = 1'b0;
      vs_pulse();
      wait_valid();
      reset = 1'b1;
      cyc(1);
      check("mr_valid", 32'(bus.cmd_valid), 0);
      check("mr_busy", 32'(busy), 0);
      check("mr_abort", 32'(abort_cnt), 0);
      cyc(2);
      reset = 1'b0;
      cyc(2);

      // randomized traffic
      random_beats = 1;
      for (int i = 0; i < 4000; i++) begin
         bus.cmd_ready = ($urandom_range(0, 9) < 7);
         fifo_level    = LVL_W'($urandom_range(0, 7));
         fbc_vsync     = fbc_vsync ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 59) == 0) enable = ~enable;
         reset         = ($urandom_range(0, 799) == 0);
         cyc(1);
      end
      reset = 1'b0;
      cyc(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
